joy_scancode_gen: RTL and testbench

//  Consumes the 12 active-low button lines from the serial joystick decoder
//  (2 players x up/down/left/right/fire1/fire2). Synchronises, debounces and

---
 rtl/joy_scancode_gen.sv | 183 ++++++++++++++++++
 tb/tb_joy_scancode_gen.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/joy_scancode_gen.sv
// Joystick buttons to PS/2 set-2 make/break bytes: 2-FF sync, 3-sample debounce, lowest-index-first FSM.
// Optional autofire on fire1 is built only when JOY_AUTOFIRE_EN is defined.
module joy_scancode_gen #(
    parameter int TICK_DIV     = 1000,
    parameter int AUTOFIRE_DIV = 50
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] joy1_n,
    input  logic [5:0] joy2_n,
    input  logic       autofire_on,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       busy
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, PREFIX, BRK, CODE} state_t;

    state_t      state, next_state;
    logic [11:0] raw, sync1, sync2, smp1, smp2, deb, view, reported, pend, agree;
    logic [TW-1:0] tick_cnt;
    logic        tick;
    logic        sel_found;
    logic [3:0]  sel_idx, idx_q;
    logic        brk_q;

    assign raw  = {joy2_n, joy1_n};
    assign tick = (tick_cnt == TW'(TICK_DIV - 1));

    // A line's debounced value moves only when this sample and the two before it agree.
    assign agree = ~(sync2 ^ smp1) & ~(smp1 ^ smp2);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '1;
            sync2    <= '1;
            smp1     <= '1;
            smp2     <= '1;
            deb      <= '1;
            tick_cnt <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (tick) begin
                tick_cnt <= '0;
                smp1     <= sync2;
                smp2     <= smp1;
                deb      <= (agree & sync2) | (~agree & deb);
            end else begin
                tick_cnt <= tick_cnt + 1'b1;
            end
        end
    end

`ifdef JOY_AUTOFIRE_EN
    localparam int AW = (AUTOFIRE_DIV > 1) ? $clog2(AUTOFIRE_DIV) : 1;

    logic [AW-1:0] af_cnt [2];
    logic [1:0]    af_phase;
    logic [1:0]    af_act;

    // Phase 0 means "pressed", so an autofire burst always opens with a make.
    assign af_act = {autofire_on & ~deb[10], autofire_on & ~deb[4]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            af_cnt[0] <= '0;
            af_cnt[1] <= '0;
            af_phase  <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (!af_act[p]) begin
                    af_cnt[p]   <= '0;
                    af_phase[p] <= 1'b0;
                end else if (tick) begin
                    if (af_cnt[p] == AW'(AUTOFIRE_DIV - 1)) begin
                        af_cnt[p]   <= '0;
                        af_phase[p] <= ~af_phase[p];
                    end else begin
                        af_cnt[p] <= af_cnt[p] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        view = deb;
        if (af_act[0]) view[4]  = af_phase[0];
        if (af_act[1]) view[10] = af_phase[1];
    end
`else
    logic unused_autofire;
    assign unused_autofire = autofire_on;
    assign view            = deb;
`endif

    assign pend = view ^ reported;

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = 11; i >= 0; i--) begin
            if (pend[i]) begin
                sel_found = 1'b1;
                sel_idx   = 4'(i);
            end
        end
    end

    function automatic logic [7:0] code_of(input logic [3:0] idx);
        case (idx)
            4'd0:    code_of = 8'h75;
            4'd1:    code_of = 8'h72;
            4'd2:    code_of = 8'h6B;
            4'd3:    code_of = 8'h74;
            4'd4:    code_of = 8'h14;
            4'd5:    code_of = 8'h11;
            4'd6:    code_of = 8'h1D;
            4'd7:    code_of = 8'h1B;
            4'd8:    code_of = 8'h1C;
            4'd9:    code_of = 8'h23;
            4'd10:   code_of = 8'h12;
            4'd11:   code_of = 8'h1A;
            default: code_of = 8'h00;
        endcase
    endfunction

    always_comb begin
        next_state = state;
        scan_code  = 8'h00;
        scan_valid = 1'b0;
        busy       = 1'b0;
        case (state)
            IDLE: begin
                if (sel_found) begin
                    if (sel_idx < 4'd4)     next_state = PREFIX;
                    else if (view[sel_idx]) next_state = BRK;
                    else                    next_state = CODE;
                end
            end
            PREFIX: begin
                scan_code  = 8'hE0;
                scan_valid = 1'b1;
                busy       = 1'b1;
                if (scan_ready) next_state = brk_q ? BRK : CODE;
            end
            BRK: begin
                scan_code  = 8'hF0;
                scan_valid = 1'b1;
                busy       = 1'b1;
                if (scan_ready) next_state = CODE;
            end
            CODE: begin
                scan_code  = code_of(idx_q);
                scan_valid = 1'b1;
                busy       = 1'b1;
                if (scan_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx_q    <= '0;
            brk_q    <= 1'b0;
            reported <= '1;
        end else begin
            state <= next_state;
            if (state == IDLE && sel_found) begin
                idx_q <= sel_idx;
                brk_q <= view[sel_idx];
            end
            if (state == CODE && scan_ready) reported[idx_q] <= brk_q;
        end
    end

endmodule

// File: tb/tb_joy_scancode_gen.sv
// Bench for joy_scancode_gen: expected byte streams come from the key table and
// "changed lines, lowest index first" rule; accepted bytes are collected at the falling edge.
module tb_joy_scancode_gen;

    localparam int TICK_DIV     = 4;
    localparam int AUTOFIRE_DIV = 2;
    localparam logic [7:0] CODES [0:11] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11,
                                            8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h12, 8'h1A};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] joy1_n, joy2_n;
    logic       autofire_on;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       scan_ready;
    logic       busy;

    logic [7:0]  got [$];
    logic [7:0]  exp [$];
    logic [11:0] model_rep;
    int          checks   = 0;
    int          failures = 0;

    joy_scancode_gen #(.TICK_DIV(TICK_DIV), .AUTOFIRE_DIV(AUTOFIRE_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .joy1_n(joy1_n), .joy2_n(joy2_n),
        .autofire_on(autofire_on), .scan_code(scan_code), .scan_valid(scan_valid),
        .scan_ready(scan_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && scan_valid && scan_ready) got.push_back(scan_code);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_lines(input logic [11:0] v);
        joy1_n = v[5:0];
        joy2_n = v[11:6];
    endtask

    task automatic push_seq(input int i, input bit brk);
        if (i < 4) exp.push_back(8'hE0);
        if (brk) exp.push_back(8'hF0);
        exp.push_back(CODES[i]);
    endtask

    // Drive a new line state and append the sequences it must cause.
    task automatic model_apply(input logic [11:0] v);
        for (int i = 0; i < 12; i++)
            if (v[i] != model_rep[i]) push_seq(i, v[i]);
        model_rep = v;
        set_lines(v);
    endtask

    task automatic wait_quiet(input bit rnd, output bit to);
        int idle = 0;
        to = 1'b1;
        repeat (TICK_DIV * 6) begin
            step(1);
            if (rnd) scan_ready = 1'($urandom_range(0, 1));
        end
        for (int n = 0; n < 800; n++) begin
            step(1);
            if (rnd) scan_ready = 1'($urandom_range(0, 1));
            idle = busy ? 0 : idle + 1;
            if (idle >= 3) begin
                to = 1'b0;
                break;
            end
        end
        scan_ready = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(3);
        @(negedge clk);
        checks++;
        if (scan_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", scan_valid); end
        checks++;
        if (scan_code !== 8'h00) begin failures++; $display("FAIL reset_code: got %h expected 00", scan_code); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_rep = '1;
        step(2);
    endtask

    task automatic test_single;
        bit to;
        got.delete(); exp.delete();
        model_apply(12'hFFE);
        step(20);
        wait_quiet(0, to);
        model_apply(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (to) begin failures++; $display("FAIL single_timeout: busy never settled, expected idle"); end
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL single_len: got %0d bytes expected %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL single_byte%0d: got %h expected %h", k, got[k], exp[k]); end
        end
        got.delete();
        step(60);
        checks++;
        if (got.size() != 0) begin failures++; $display("FAIL single_extra: got %0d bytes expected 0", got.size()); end
    endtask

    task automatic test_glitch;
        bit to;
        got.delete(); exp.delete();
        set_lines(12'hBFF);
        step(TICK_DIV);
        set_lines(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (got.size() != 0) begin failures++; $display("FAIL glitch_len: got %0d bytes expected 0", got.size()); end
        model_apply(12'hBFF);
        wait_quiet(0, to);
        model_apply(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (to) begin failures++; $display("FAIL glitch_timeout: busy never settled, expected idle"); end
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL glitch_len2: got %0d bytes expected %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL glitch_byte%0d: got %h expected %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_simultaneous;
        bit to;
        got.delete(); exp.delete();
        model_apply(12'hDFB);
        wait_quiet(0, to);
        model_apply(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (to) begin failures++; $display("FAIL simul_timeout: busy never settled, expected idle"); end
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL simul_len: got %0d bytes expected %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL simul_byte%0d: got %h expected %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_backpressure;
        bit to;
        bit seen = 1'b0;
        got.delete(); exp.delete();
        scan_ready = 1'b0;
        model_apply(12'hFFD);
        for (int n = 0; n < 100 && !seen; n++) begin
            step(1);
            seen = scan_valid;
        end
        checks++;
        if (!seen) begin failures++; $display("FAIL bp_start: scan_valid stayed 0, expected 1"); end
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if (scan_valid !== 1'b1 || scan_code !== 8'hE0)
                begin failures++; $display("FAIL bp_hold%0d: got valid=%b code=%h expected valid=1 code=e0", n, scan_valid, scan_code); end
        end
        @(posedge clk);
        #1 scan_ready = 1'b1;
        wait_quiet(0, to);
        model_apply(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL bp_len: got %0d bytes expected %0d", got.size(), exp.size()); end
        for (int k = 0; k < got.size() && k < exp.size(); k++) begin
            checks++;
            if (got[k] !== exp[k]) begin failures++; $display("FAIL bp_byte%0d: got %h expected %h", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_random;
        bit to;
        for (int r = 0; r < 10; r++) begin
            got.delete(); exp.delete();
            model_apply(12'($urandom()));
            wait_quiet(1, to);
            checks++;
            if (to) begin failures++; $display("FAIL rand%0d_timeout: busy never settled, expected idle", r); end
            checks++;
            if (got.size() != exp.size()) begin failures++; $display("FAIL rand%0d_len: got %0d bytes expected %0d", r, got.size(), exp.size()); end
            for (int k = 0; k < got.size() && k < exp.size(); k++) begin
                checks++;
                if (got[k] !== exp[k]) begin failures++; $display("FAIL rand%0d_byte%0d: got %h expected %h", r, k, got[k], exp[k]); end
            end
        end
        got.delete(); exp.delete();
        model_apply(12'hFFF);
        wait_quiet(0, to);
        checks++;
        if (got.size() != exp.size()) begin failures++; $display("FAIL rand_drain_len: got %0d bytes expected %0d", got.size(), exp.size()); end
    endtask

    task automatic test_reset_mid;
        bit to;
        bit seen = 1'b0;
        model_apply(12'hFFE);
        wait_quiet(0, to);
        scan_ready = 1'b0;
        model_apply(12'hFFF);
        for (int n = 0; n < 100 && !seen; n++) begin
            step(1);
            seen = scan_valid;
        end
        scan_ready = 1'b1;
        step(1);
        scan_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (scan_valid !== 1'b1 || scan_code !== 8'hF0)
            begin failures++; $display("FAIL rstmid_brk: got valid=%b code=%h expected valid=1 code=f0", scan_valid, scan_code); end
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (scan_valid !== 1'b0 || busy !== 1'b0)
            begin failures++; $display("FAIL rstmid_abort: got valid=%b busy=%b expected 0 0", scan_valid, busy); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        scan_ready = 1'b1;
        model_rep = '1;
        got.delete();
        wait_quiet(0, to);
        step(40);
        checks++;
        if (got.size() != 0) begin failures++; $display("FAIL rstmid_resume: got %0d bytes expected 0", got.size()); end
    endtask

`ifdef JOY_AUTOFIRE_EN
    task automatic test_autofire;
        bit to;
        int p = 0;
        int nmk = 0;
        bit mk = 1'b1;
        bit bad = 1'b0;
        got.delete();
        autofire_on = 1'b1;
        set_lines(12'hFEF);
        step(TICK_DIV * 16);
        set_lines(12'hFFF);
        wait_quiet(0, to);
        autofire_on = 1'b0;
        while (p < got.size()) begin
            if (mk) begin
                if (got[p] !== 8'h14) bad = 1'b1;
                p++;
                nmk++;
            end else begin
                if (p + 1 >= got.size() || got[p] !== 8'hF0 || got[p+1] !== 8'h14) bad = 1'b1;
                p += 2;
            end
            mk = !mk;
        end
        checks++;
        if (bad) begin failures++; $display("FAIL af_pattern: got %0d bytes not alternating 14 / f0 14", got.size()); end
        checks++;
        if (nmk < 3) begin failures++; $display("FAIL af_repeat: got %0d makes expected at least 3", nmk); end
        checks++;
        if (!mk) begin failures++; $display("FAIL af_final: got last sequence make expected break"); end
    endtask
`endif

    initial begin
        rst_n       = 1'b0;
        autofire_on = 1'b0;
        scan_ready  = 1'b1;
        set_lines(12'hFFF);
        model_rep   = '1;
        test_reset;
        test_single;
        test_glitch;
        test_simultaneous;
        test_backpressure;
        test_random;
        test_reset_mid;
`ifdef JOY_AUTOFIRE_EN
        test_autofire;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
